qar_pwm: RTL and testbench

- Two-channel PWM generator on the peripheral bus; feeds the GPIO block's alternate-function inputs: pwm0 drives alt_pwm0, pwm1 drives alt_pwm1.
- Shared prescaler and period counter, per-channel duty and polarity.
- Shadowed period and duty registers so updates are glitch-free.
- Period-wrap interrupt with a write-1-to-clear status bit.

---
 rtl/qar_pwm.sv | 177 +++++++++++++++++
 tb/tb_qar_pwm.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qar_pwm.sv
// qar_pwm: two-channel PWM generator with a bus register interface.
// Shared prescaler and period counter; per-channel duty and polarity.
// PERIOD/DUTY writes land in pending copies and reach the active copies
// only while disabled or on a period wrap, so outputs never glitch.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   write_en   single-cycle bus write strobe
//   read_en    bus read strobe
//   addr_word  register word offset
//   wdata      write data
//   rdata      combinational read data (0 when idle or unmapped)
//   pwm0/pwm1  registered channel outputs (to GPIO alt_pwm0/alt_pwm1)
//   irq        STATUS.WRAP & CTRL.IRQ_EN
module qar_pwm #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned PRE_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        write_en,
  input  logic        read_en,
  input  logic [4:0]  addr_word,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        pwm0,
  output logic        pwm1,
  output logic        irq
);

  localparam logic [4:0] A_CTRL   = 5'd0;
  localparam logic [4:0] A_PRESC  = 5'd1;
  localparam logic [4:0] A_PERIOD = 5'd2;
  localparam logic [4:0] A_DUTY0  = 5'd3;
  localparam logic [4:0] A_DUTY1  = 5'd4;
  localparam logic [4:0] A_COUNT  = 5'd5;
  localparam logic [4:0] A_STATUS = 5'd6;

  // CTRL bits: [0] EN, [1] POL0, [2] POL1, [3] IRQ_EN
  logic [3:0]       ctrl_q,       ctrl_d;
  logic [PRE_W-1:0] presc_q,      presc_d;
  logic [PRE_W-1:0] presc_cnt_q,  presc_cnt_d;
  logic [CNT_W-1:0] period_pnd_q, period_pnd_d;
  logic [CNT_W-1:0] duty0_pnd_q,  duty0_pnd_d;
  logic [CNT_W-1:0] duty1_pnd_q,  duty1_pnd_d;
  logic [CNT_W-1:0] period_act_q, period_act_d;
  logic [CNT_W-1:0] duty0_act_q,  duty0_act_d;
  logic [CNT_W-1:0] duty1_act_q,  duty1_act_d;
  logic [CNT_W-1:0] count_q,      count_d;
  logic             wrap_q,       wrap_d;
  logic             pwm0_q,       pwm0_d;
  logic             pwm1_q,       pwm1_d;

  logic en_c;
  logic tick_c;
  logic wrap_c;
  logic unused_wdata_c;

  assign en_c   = ctrl_q[0];
  assign tick_c = en_c && (presc_cnt_q == presc_q);
  assign wrap_c = tick_c && (count_q == period_act_q);

  // Only the low bits of wdata are architecturally meaningful.
  assign unused_wdata_c = ^wdata;

  // Next-state logic for counters, shadows, status and outputs.
  always_comb begin
    ctrl_d       = ctrl_q;
    presc_d      = presc_q;
    presc_cnt_d  = presc_cnt_q;
    period_pnd_d = period_pnd_q;
    duty0_pnd_d  = duty0_pnd_q;
    duty1_pnd_d  = duty1_pnd_q;
    period_act_d = period_act_q;
    duty0_act_d  = duty0_act_q;
    duty1_act_d  = duty1_act_q;
    count_d      = count_q;
    wrap_d       = wrap_q;
    pwm0_d       = ctrl_q[1];
    pwm1_d       = ctrl_q[2];

    if (en_c) begin
      // presc_cnt free-runs past PRESCALE (wrapping at full width) if
      // PRESCALE was lowered below the current count.
      presc_cnt_d = tick_c ? '0 : presc_cnt_q + PRE_W'(1);
      if (tick_c) begin
        count_d = wrap_c ? '0 : count_q + CNT_W'(1);
      end
      pwm0_d = (count_q < duty0_act_q) ^ ctrl_q[1];
      pwm1_d = (count_q < duty1_act_q) ^ ctrl_q[2];
    end else begin
      presc_cnt_d = '0;
      count_d     = '0;
    end

    // Active copies take the pre-write pending value, so a write in the
    // wrap cycle only applies from the following wrap.
    if (!en_c || wrap_c) begin
      period_act_d = period_pnd_q;
      duty0_act_d  = duty0_pnd_q;
      duty1_act_d  = duty1_pnd_q;
    end

    if (write_en) begin
      unique case (addr_word)
        A_CTRL:   ctrl_d       = wdata[3:0];
        A_PRESC:  presc_d      = wdata[PRE_W-1:0];
        A_PERIOD: period_pnd_d = wdata[CNT_W-1:0];
        A_DUTY0:  duty0_pnd_d  = wdata[CNT_W-1:0];
        A_DUTY1:  duty1_pnd_d  = wdata[CNT_W-1:0];
        A_STATUS: if (wdata[0]) wrap_d = 1'b0;
        default:  ;
      endcase
    end

    // A wrap in the same cycle as a clear wins.
    if (wrap_c) begin
      wrap_d = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q       <= '0;
      presc_q      <= '0;
      presc_cnt_q  <= '0;
      period_pnd_q <= '0;
      duty0_pnd_q  <= '0;
      duty1_pnd_q  <= '0;
      period_act_q <= '0;
      duty0_act_q  <= '0;
      duty1_act_q  <= '0;
      count_q      <= '0;
      wrap_q       <= 1'b0;
      pwm0_q       <= 1'b0;
      pwm1_q       <= 1'b0;
    end else begin
      ctrl_q       <= ctrl_d;
      presc_q      <= presc_d;
      presc_cnt_q  <= presc_cnt_d;
      period_pnd_q <= period_pnd_d;
      duty0_pnd_q  <= duty0_pnd_d;
      duty1_pnd_q  <= duty1_pnd_d;
      period_act_q <= period_act_d;
      duty0_act_q  <= duty0_act_d;
      duty1_act_q  <= duty1_act_d;
      count_q      <= count_d;
      wrap_q       <= wrap_d;
      pwm0_q       <= pwm0_d;
      pwm1_q       <= pwm1_d;
    end
  end

  // Combinational read mux, zero-extended.
  always_comb begin
    rdata = '0;
    if (read_en) begin
      unique case (addr_word)
        A_CTRL:   rdata = 32'(ctrl_q);
        A_PRESC:  rdata = 32'(presc_q);
        A_PERIOD: rdata = 32'(period_pnd_q);
        A_DUTY0:  rdata = 32'(duty0_pnd_q);
        A_DUTY1:  rdata = 32'(duty1_pnd_q);
        A_COUNT:  rdata = 32'(count_q);
        A_STATUS: rdata = 32'(wrap_q);
        default:  rdata = '0;
      endcase
    end
  end

  assign pwm0 = pwm0_q;
  assign pwm1 = pwm1_q;
  assign irq  = wrap_q & ctrl_q[3];

endmodule

// File: tb/tb_qar_pwm.sv
// tb_qar_pwm: register table, directed PWM/shadow/IRQ/disable/reset
// sequences and random bus traffic, all checked every cycle against a
// behavioural model of the PWM rules.
module tb_qar_pwm;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned PRE_W = 16;
  localparam longint unsigned CMASK = (64'd1 << CNT_W) - 64'd1;
  localparam longint unsigned PMASK = (64'd1 << PRE_W) - 64'd1;

  logic        clk = 1'b0;
  logic        rst;
  logic        write_en;
  logic        read_en;
  logic [4:0]  addr_word;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        pwm0;
  logic        pwm1;
  logic        irq;

  qar_pwm #(.CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
    .clk(clk), .rst(rst), .write_en(write_en), .read_en(read_en),
    .addr_word(addr_word), .wdata(wdata), .rdata(rdata),
    .pwm0(pwm0), .pwm1(pwm1), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state
  longint unsigned m_ctrl, m_pre, m_pc, m_cnt;
  longint unsigned m_per_p, m_d0_p, m_d1_p, m_per_a, m_d0_a, m_d1_a;
  bit m_wrap, m_pwm0, m_pwm1;

  bit          obs_pwm0, obs_pwm1, obs_irq;
  logic [31:0] obs_rdata;

  typedef struct {
    bit          we;
    bit          re;
    int          a;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint unsigned m_read(input int a);
    case (a)
      0: return m_ctrl;
      1: return m_pre;
      2: return m_per_p;
      3: return m_d0_p;
      4: return m_d1_p;
      5: return m_cnt;
      6: return longint'(m_wrap);
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_ctrl = 0; m_pre = 0; m_pc = 0; m_cnt = 0;
    m_per_p = 0; m_d0_p = 0; m_d1_p = 0;
    m_per_a = 0; m_d0_a = 0; m_d1_a = 0;
    m_wrap = 0; m_pwm0 = 0; m_pwm1 = 0;
  endtask

  // One clock of the PWM rules, evaluated from the pre-edge state.
  task automatic model_step(input bit we, input int a, input logic [31:0] wd);
    bit en, pol0, pol1, tick, wrap_ev;
    longint unsigned pc_n, cnt_n;
    en = m_ctrl[0]; pol0 = m_ctrl[1]; pol1 = m_ctrl[2];
    wrap_ev = 0; pc_n = 0; cnt_n = 0;
    if (en) begin
      tick = (m_pc == m_pre);
      pc_n = tick ? 0 : ((m_pc + 1) & PMASK);
      cnt_n = m_cnt;
      if (tick) begin
        if (m_cnt == m_per_a) begin
          cnt_n = 0;
          wrap_ev = 1;
        end else begin
          cnt_n = (m_cnt + 1) & CMASK;
        end
      end
      m_pwm0 = (m_cnt < m_d0_a) ^ pol0;
      m_pwm1 = (m_cnt < m_d1_a) ^ pol1;
    end else begin
      m_pwm0 = pol0;
      m_pwm1 = pol1;
    end
    if (!en || wrap_ev) begin
      m_per_a = m_per_p; m_d0_a = m_d0_p; m_d1_a = m_d1_p;
    end
    if (we && a == 6 && wd[0]) m_wrap = 0;
    if (wrap_ev) m_wrap = 1;
    if (we) begin
      case (a)
        0: m_ctrl  = longint'(wd) & 64'hF;
        1: m_pre   = longint'(wd) & PMASK;
        2: m_per_p = longint'(wd) & CMASK;
        3: m_d0_p  = longint'(wd) & CMASK;
        4: m_d1_p  = longint'(wd) & CMASK;
        default: ;
      endcase
    end
    m_pc = pc_n;
    m_cnt = cnt_n;
  endtask

  // Drive one bus cycle, check all outputs against the model, advance.
  task automatic cycle(input bit we, input bit re, input int a, input logic [31:0] wd);
    @(negedge clk);
    write_en = we; read_en = re; addr_word = 5'(a); wdata = wd;
    #1;
    obs_pwm0 = pwm0; obs_pwm1 = pwm1; obs_irq = irq; obs_rdata = rdata;
    chk("pwm0", 32'(pwm0), 32'(m_pwm0));
    chk("pwm1", 32'(pwm1), 32'(m_pwm1));
    chk("irq", 32'(irq), 32'(m_wrap & m_ctrl[3]));
    chk("rdata", rdata, re ? 32'(m_read(a)) : 32'd0);
    @(posedge clk);
    model_step(we, a, wd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 32'd0);
  endtask

  // Advance until the active counter equals v (bounded).
  task automatic wait_cnt(input longint unsigned v, input string name);
    int k;
    k = 0;
    while (m_cnt != v && k < 300) begin
      cycle(0, 0, 0, 32'd0);
      k++;
    end
    if (m_cnt != v) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: timeout waiting for count %0d", name, v);
    end
  endtask

  task automatic async_reset();
    @(negedge clk);
    write_en = 0; read_en = 0;
    #2 rst = 1'b1;
    #1;
    chk("rst_pwm0", 32'(pwm0), 32'd0);
    chk("rst_pwm1", 32'(pwm1), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Count high samples of each channel over n cycles, reading COUNT.
  task automatic count_high(input int n, output int h0, output int h1);
    h0 = 0; h1 = 0;
    for (int i = 0; i < n; i++) begin
      cycle(0, 1, 5, 32'd0);
      h0 += int'(obs_pwm0);
      h1 += int'(obs_pwm1);
    end
  endtask

  initial begin
    int h0, h1;
    bit we, re;
    int a;
    logic [31:0] wd;

    rst = 1'b0; write_en = 0; read_en = 0; addr_word = '0; wdata = '0;
    model_reset();
    async_reset();

    // Register map / reset defaults
    tbl[0]  = '{0, 1, 0, 32'd0, 32'd0};
    tbl[1]  = '{0, 1, 1, 32'd0, 32'd0};
    tbl[2]  = '{0, 1, 2, 32'd0, 32'd0};
    tbl[3]  = '{0, 1, 3, 32'd0, 32'd0};
    tbl[4]  = '{0, 1, 4, 32'd0, 32'd0};
    tbl[5]  = '{0, 1, 5, 32'd0, 32'd0};
    tbl[6]  = '{0, 1, 6, 32'd0, 32'd0};
    tbl[7]  = '{0, 1, 9, 32'd0, 32'd0};
    tbl[8]  = '{1, 0, 1, 32'hFFFF_0005, 32'd0};
    tbl[9]  = '{0, 1, 1, 32'd0, 32'h0000_0005};
    tbl[10] = '{1, 0, 2, 32'h1234_ABCD, 32'd0};
    tbl[11] = '{0, 1, 2, 32'd0, 32'h0000_ABCD};
    tbl[12] = '{1, 0, 0, 32'hFFFF_FFFE, 32'd0};
    tbl[13] = '{0, 1, 0, 32'd0, 32'h0000_000E};
    tbl[14] = '{1, 0, 6, 32'd1, 32'd0};
    tbl[15] = '{0, 1, 5, 32'd0, 32'd0};
    tbl[16] = '{1, 0, 0, 32'd0, 32'd0};
    tbl[17] = '{0, 1, 0, 32'd0, 32'd0};
    foreach (tbl[i]) begin
      cycle(tbl[i].we, tbl[i].re, tbl[i].a, tbl[i].wd);
      if (tbl[i].re) chk($sformatf("tbl%0d", i), obs_rdata, tbl[i].exp);
    end

    // Basic duty: period 10, duty0 3, duty1 > period
    cycle(1, 0, 1, 32'd0);
    cycle(1, 0, 2, 32'd9);
    cycle(1, 0, 3, 32'd3);
    cycle(1, 0, 4, 32'd10);
    cycle(1, 0, 0, 32'd1);
    idle(3);
    count_high(20, h0, h1);
    chk("basic_hi0", 32'(h0), 32'd6);
    chk("basic_hi1", 32'(h1), 32'd20);

    // Shadow: mid-period DUTY0 write applies after the next wrap
    wait_cnt(5, "shadow_wait5");
    cycle(1, 0, 3, 32'd7);
    cycle(0, 1, 3, 32'd0);
    chk("duty0_pend", obs_rdata, 32'd7);
    wait_cnt(0, "shadow_wait0");
    count_high(10, h0, h1);
    chk("shadow_hi", 32'(h0), 32'd7);

    // Write in the exact wrap cycle applies one period later
    wait_cnt(9, "wrapw_wait9");
    cycle(1, 0, 3, 32'd2);
    count_high(10, h0, h1);
    chk("wrapw_hi_old", 32'(h0), 32'd7);
    count_high(10, h0, h1);
    chk("wrapw_hi_new", 32'(h0), 32'd2);

    // Prescale + inverted polarity
    cycle(1, 0, 0, 32'd0);
    cycle(1, 0, 1, 32'd3);
    cycle(1, 0, 2, 32'd4);
    cycle(1, 0, 3, 32'd2);
    cycle(1, 0, 0, 32'd3);
    idle(5);
    count_high(40, h0, h1);
    chk("presc_hi0", 32'(h0), 32'd24);

    // IRQ on wrap, W1C, and clear coinciding with a wrap
    cycle(1, 0, 0, 32'd0);
    cycle(1, 0, 6, 32'd1);
    cycle(1, 0, 1, 32'd0);
    cycle(1, 0, 2, 32'd4);
    cycle(1, 0, 0, 32'd9);
    wait_cnt(4, "irq_wait4");
    cycle(0, 0, 0, 32'd0);
    chk("irq_pre", 32'(obs_irq), 32'd0);
    cycle(0, 0, 0, 32'd0);
    chk("irq_rise", 32'(obs_irq), 32'd1);
    cycle(1, 0, 6, 32'd1);
    cycle(0, 0, 0, 32'd0);
    chk("irq_clr", 32'(obs_irq), 32'd0);
    wait_cnt(4, "w1c_wait4");
    cycle(1, 0, 6, 32'd1);
    cycle(0, 1, 6, 32'd0);
    chk("w1c_wrap_irq", 32'(obs_irq), 32'd1);
    chk("w1c_wrap_stat", obs_rdata, 32'd1);

    // Disable mid-run returns count to 0 and pwm to idle polarity
    cycle(1, 0, 0, 32'd0);
    cycle(1, 0, 6, 32'd1);
    cycle(1, 0, 2, 32'd9);
    cycle(1, 0, 3, 32'd3);
    cycle(1, 0, 0, 32'd3);
    wait_cnt(5, "dis_wait5");
    cycle(1, 0, 0, 32'd2);
    cycle(0, 1, 5, 32'd0);
    chk("dis_cnt6", obs_rdata, 32'd6);
    cycle(0, 1, 5, 32'd0);
    chk("dis_cnt0", obs_rdata, 32'd0);
    chk("dis_pol0", 32'(obs_pwm0), 32'd1);

    // Asynchronous reset mid-period with POL0=1
    cycle(1, 0, 0, 32'd3);
    idle(6);
    async_reset();
    for (int i = 0; i < 7; i++) begin
      cycle(0, 1, i, 32'd0);
      chk($sformatf("post_rst%0d", i), obs_rdata, 32'd0);
    end

    // Random bus traffic against the model
    for (int n = 0; n < 600; n++) begin
      we = ($urandom_range(0, 5) == 0);
      re = 1'($urandom_range(0, 1));
      a  = int'($urandom_range(0, 7));
      case (a)
        0: wd = ($urandom() & ~32'd1) | 32'($urandom_range(0, 4) != 0);
        1: wd = ($urandom() & 32'hFFFF_0000) | 32'($urandom_range(0, 3));
        2, 3, 4: wd = 32'($urandom_range(0, 12));
        default: wd = $urandom();
      endcase
      cycle(we, re, a, wd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
